// File: rtl/motor_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_ctrl
// Purpose  : Memory-mapped four-channel motor PWM controller. Decodes a
//            16-word MMIO window on the data-memory bus, holds the
//            configuration registers, generates glitch-free PWM from a
//            prescaled period counter and routes H-bridge direction changes
//            through a per-channel dead-time (coast) interval.
// Ports    : clock, reset        - system clock, synchronous active-high reset
//            wEn, addr, dataIn   - dmem write enable, word address, write data
//            dataOut, hit        - registered read data / window-hit flag
//            PWMSignals[3:0]     - one PWM output per channel
//            Directions[7:0]     - 2 bits per channel, 00 = coast
// Options  : MOTOR_PWM_WATCHDOG_EN - builds a write-activity watchdog that
//            drops CTRL.en and sets STATUS.wdog after WDOG_CYCLES idle clocks.
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_ctrl #(
    parameter logic [7:0] BASE        = 8'hF0,
    parameter int         DEAD_CYCLES = 16,
    parameter int         WDOG_CYCLES = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wEn,
    input  logic [11:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        hit,
    output logic [3:0]  PWMSignals,
    output logic [7:0]  Directions
);

    localparam logic [7:0] c_DEAD      = 8'(DEAD_CYCLES);
    localparam logic       c_WDOG_LSB  = WDOG_CYCLES[0];
    localparam logic [3:0] c_OFS_CTRL  = 4'h0;
    localparam logic [3:0] c_OFS_PRE   = 4'h1;
    localparam logic [3:0] c_OFS_PER   = 4'h2;
    localparam logic [3:0] c_OFS_STAT  = 4'h3;
    localparam logic [3:0] c_OFS_DIR   = 4'h8;

    // Configuration / status registers
    logic        r_en;
    logic [15:0] r_prescale;
    logic [7:0]  r_period;
    logic        r_wrap;
    logic        r_wdog;
    logic [7:0]  r_dir;
    logic [7:0]  r_shadow [4];

    // Counters
    logic [15:0] r_pcnt;
    logic [7:0]  r_cnt;

    logic        w_sel;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_wr_dir;
    logic        w_en_nxt;
    logic        w_tick;
    logic        w_boundary;
    logic        w_wdog_fire;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel     = (addr[11:4] == BASE);
    assign w_wr      = wEn & w_sel;
    assign w_wr_ctrl = w_wr && (addr[3:0] == c_OFS_CTRL);
    assign w_wr_stat = w_wr && (addr[3:0] == c_OFS_STAT);
    assign w_wr_dir  = w_wr && (addr[3:0] == c_OFS_DIR);

    // Bits that are accepted on the bus but carry no meaning here.
    assign w_unused = ^{dataIn[31:16], c_WDOG_LSB};

    // Enable as it will be after this edge; a disabling write (or watchdog
    // expiry) overrides a coincident tick so the counters land on 0.
    always_comb begin
        w_en_nxt = r_en;
        if (w_wr_ctrl) begin
            w_en_nxt = dataIn[0];
        end
        if (w_wdog_fire) begin
            w_en_nxt = 1'b0;
        end
    end

    assign w_tick     = r_en && (r_pcnt == r_prescale);
    // Using >= lets a PERIOD shrink below the running count end the period
    // on the very next tick instead of wrapping through 255.
    assign w_boundary = w_tick && (r_cnt >= r_period) && w_en_nxt;

`ifdef MOTOR_PWM_WATCHDOG_EN
    localparam int                  c_WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LOAD = c_WDOG_W'(WDOG_CYCLES);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE  = c_WDOG_W'(1);

    logic [c_WDOG_W-1:0] r_wdog_cnt;

    always_ff @(posedge clock) begin
        if (reset || w_wr) begin
            r_wdog_cnt <= c_WDOG_LOAD;
        end else if (r_wdog_cnt != '0) begin
            r_wdog_cnt <= r_wdog_cnt - c_WDOG_ONE;
        end
    end

    // Fires once, on the 1 -> 0 step; the counter then parks at 0.
    assign w_wdog_fire = (r_wdog_cnt == c_WDOG_ONE) && !w_wr;
`else
    assign w_wdog_fire = 1'b0;
`endif

    // Register file
    always_ff @(posedge clock) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_prescale <= 16'd0;
            r_period   <= 8'd255;
            r_wrap     <= 1'b0;
            r_wdog     <= 1'b0;
            r_dir      <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 8'd0;
            end
        end else begin
            r_en <= w_en_nxt;
            if (w_wr && (addr[3:0] == c_OFS_PRE)) begin
                r_prescale <= dataIn[15:0];
            end
            if (w_wr && (addr[3:0] == c_OFS_PER)) begin
                r_period <= dataIn[7:0];
            end
            if (w_wr_dir) begin
                r_dir <= dataIn[7:0];
            end
            if (w_wr && (addr[3:2] == 2'b01)) begin
                r_shadow[addr[1:0]] <= dataIn[7:0];
            end
            // Hardware set takes priority over a write-1-to-clear.
            if (w_boundary) begin
                r_wrap <= 1'b1;
            end else if (w_wr_stat && dataIn[0]) begin
                r_wrap <= 1'b0;
            end
            if (w_wdog_fire) begin
                r_wdog <= 1'b1;
            end else if (w_wr_stat && dataIn[1]) begin
                r_wdog <= 1'b0;
            end
        end
    end

    // Prescaler and period counter; both held at 0 while disabled.
    always_ff @(posedge clock) begin
        if (reset || !w_en_nxt || !r_en) begin
            r_pcnt <= 16'd0;
            r_cnt  <= 8'd0;
        end else if (w_tick) begin
            r_pcnt <= 16'd0;
            r_cnt  <= (r_cnt >= r_period) ? 8'd0 : r_cnt + 8'd1;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    // Per-channel duty, dead-time and output stage
    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [7:0] r_active;
        logic [7:0] r_dead_cnt;
        logic       r_pwm;
        logic [1:0] r_dirs;
        logic       w_dir_chg;

        assign w_dir_chg = w_wr_dir && (dataIn[2*i +: 2] != r_dir[2*i +: 2]);

        always_ff @(posedge clock) begin
            if (reset) begin
                r_active   <= 8'd0;
                r_dead_cnt <= 8'd0;
                r_pwm      <= 1'b0;
                r_dirs     <= 2'b00;
            end else begin
                // Shadow is transparent while disabled, latched at the
                // period boundary while running, so no runt pulses.
                if (!r_en || w_boundary) begin
                    r_active <= r_shadow[i];
                end
                // A fresh change restarts the coast; newest target wins.
                if (w_dir_chg) begin
                    r_dead_cnt <= c_DEAD;
                end else if (r_dead_cnt != 8'd0) begin
                    r_dead_cnt <= r_dead_cnt - 8'd1;
                end
                r_pwm  <= r_en && (r_cnt < r_active) && (r_dead_cnt == 8'd0);
                r_dirs <= (r_dead_cnt != 8'd0) ? 2'b00 : r_dir[2*i +: 2];
            end
        end

        assign PWMSignals[i]       = r_pwm;
        assign Directions[2*i +: 2] = r_dirs;
    end

    // Read path, one cycle of latency like the neighbouring RAM
    always_comb begin
        w_rdata = 32'd0;
        case (addr[3:0])
            c_OFS_CTRL: w_rdata = {31'd0, r_en};
            c_OFS_PRE:  w_rdata = {16'd0, r_prescale};
            c_OFS_PER:  w_rdata = {24'd0, r_period};
            c_OFS_STAT: w_rdata = {30'd0, r_wdog, r_wrap};
            4'h4, 4'h5, 4'h6, 4'h7:
                        w_rdata = {24'd0, r_shadow[addr[1:0]]};
            c_OFS_DIR:  w_rdata = {24'd0, r_dir};
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dataOut <= 32'd0;
            hit     <= 1'b0;
        end else begin
            dataOut <= w_sel ? w_rdata : 32'd0;
            hit     <= w_sel;
        end
    end

endmodule
`default_nettype wire
